dds_lut_sequencer: RTL and testbench

Sequences port 2 (read side) of the 1024x16 dual-port waveform lookup RAM for one DDS channel. Runs a phase accumulator from a tuning word, applies a phase offset, issues RAM addresses every cycle and returns registered samples with a valid strobe to the DAC path. Tuning and offset changes are glitch-free: while running, they are applied only at the accumulator wrap. Port 1 stays with the Nios II for waveform loading.

---
 rtl/dds_lut_sequencer_if.sv | 29 ++
 rtl/dds_lut_sequencer.sv | 98 +++++++++
 tb/tb_dds_lut_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dds_lut_sequencer_if.sv
// rtl/dds_lut_sequencer_if.sv - config, RAM read-port and sample signals of one DDS channel
interface dds_lut_sequencer_if #(
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              enable;
    logic [ACC_W-1:0]  cfg_tuning;
    logic [ADDR_W-1:0] cfg_offset;
    logic              cfg_load;
    logic              cfg_ack;
    logic              phase_clear;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_chipselect;
    logic [DATA_W-1:0] ram_readdata;
    logic [DATA_W-1:0] sample_out;
    logic              sample_valid;
    logic              wrap_sync;

    modport master (
        output enable, cfg_tuning, cfg_offset, cfg_load, phase_clear, ram_readdata,
        input  cfg_ack, ram_address, ram_chipselect, sample_out, sample_valid, wrap_sync
    );

    modport slave (
        input  enable, cfg_tuning, cfg_offset, cfg_load, phase_clear, ram_readdata,
        output cfg_ack, ram_address, ram_chipselect, sample_out, sample_valid, wrap_sync
    );
endinterface

// File: rtl/dds_lut_sequencer.sv
// rtl/dds_lut_sequencer.sv - DDS phase accumulator driving the read port of the waveform LUT RAM
module dds_lut_sequencer #(
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    dds_lut_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, PENDING} state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_next;
    logic [ACC_W-1:0]  tuning_q, sh_tuning_q;
    logic [ADDR_W-1:0] offset_q, sh_offset_q, offset_eff;
    logic              shadow_valid_q, shadow_valid_d;
    logic [ACC_W:0]    sum;
    logic              step, wrap, apply, idle_load;
    logic              rd_valid_q;

    always_comb begin
        step      = (state_q != IDLE) && bus.enable;
        sum       = {1'b0, acc_q} + {1'b0, tuning_q};
        wrap      = step && !bus.phase_clear && sum[ACC_W];
        idle_load = (state_q == IDLE) && bus.cfg_load;
        // a load taken directly in IDLE supersedes any shadow still waiting
        apply     = shadow_valid_q && !idle_load && (bus.phase_clear || wrap);

        acc_next = acc_q;
        if (bus.phase_clear)
            acc_next = '0;
        else if (step)
            acc_next = sum[ACC_W-1:0];

        offset_eff = apply ? sh_offset_q : offset_q;

        shadow_valid_d = shadow_valid_q;
        if (idle_load)
            shadow_valid_d = 1'b0;
        else if (bus.cfg_load)
            shadow_valid_d = 1'b1;
        else if (apply)
            shadow_valid_d = 1'b0;

        state_d = IDLE;
        if (bus.enable)
            state_d = shadow_valid_d ? PENDING : RUN;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            tuning_q       <= '0;
            offset_q       <= '0;
            sh_tuning_q    <= '0;
            sh_offset_q    <= '0;
            shadow_valid_q <= 1'b0;
            bus.ram_address    <= '0;
            bus.ram_chipselect <= 1'b0;
            bus.wrap_sync      <= 1'b0;
            bus.cfg_ack        <= 1'b0;
            rd_valid_q         <= 1'b0;
            bus.sample_valid   <= 1'b0;
            bus.sample_out     <= '0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_next;
            shadow_valid_q <= shadow_valid_d;

            if (idle_load) begin
                tuning_q <= bus.cfg_tuning;
                offset_q <= bus.cfg_offset;
            end else if (apply) begin
                tuning_q <= sh_tuning_q;
                offset_q <= sh_offset_q;
            end

            if (bus.cfg_load && !idle_load) begin
                sh_tuning_q <= bus.cfg_tuning;
                sh_offset_q <= bus.cfg_offset;
            end

            if (step)
                bus.ram_address <= acc_next[ACC_W-1 -: ADDR_W] + offset_eff;
            bus.ram_chipselect <= step;
            bus.wrap_sync      <= wrap;
            bus.cfg_ack        <= idle_load || apply;

            // RAM registers the address, so data is valid one cycle after chipselect
            rd_valid_q       <= bus.ram_chipselect;
            bus.sample_valid <= rd_valid_q;
            if (rd_valid_q)
                bus.sample_out <= bus.ram_readdata;
        end
    end
endmodule

// File: tb/tb_dds_lut_sequencer.sv
// tb/tb_dds_lut_sequencer.sv - directed vector bench for dds_lut_sequencer
module tb_dds_lut_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dds_lut_sequencer_if #(.ACC_W(32), .ADDR_W(10), .DATA_W(16)) bus ();

    dds_lut_sequencer #(.ACC_W(32), .ADDR_W(10), .DATA_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [15:0] memf(input logic [9:0] a);
        return 16'hC000 | {6'b0, a};
    endfunction

    logic [9:0] ram_addr_q = '0;
    always @(posedge clk) ram_addr_q <= bus.ram_address;
    assign bus.ram_readdata = memf(ram_addr_q);

    typedef struct {
        logic        en, ld, clr;
        logic [31:0] tun;
        logic [9:0]  off;
        logic [9:0]  addr;
        logic        cs, wrap, ack, sv;
    } vec_t;

    vec_t tbl[31];

    function automatic vec_t mk(input logic en, ld, clr, input logic [31:0] tun,
                                input logic [9:0] off, addr, input logic cs, wrap, ack, sv);
        vec_t v;
        v.en = en; v.ld = ld; v.clr = clr; v.tun = tun; v.off = off;
        v.addr = addr; v.cs = cs; v.wrap = wrap; v.ack = ack; v.sv = sv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, ld, clr, input logic [31:0] tun, input logic [9:0] off);
        bus.enable = en; bus.cfg_load = ld; bus.phase_clear = clr;
        bus.cfg_tuning = tun; bus.cfg_offset = off;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_addr"}, 32'(bus.ram_address), 0);
        chk({tag, "_cs"}, 32'(bus.ram_chipselect), 0);
        chk({tag, "_wrap"}, 32'(bus.wrap_sync), 0);
        chk({tag, "_ack"}, 32'(bus.cfg_ack), 0);
        chk({tag, "_sv"}, 32'(bus.sample_valid), 0);
        chk({tag, "_sample"}, 32'(bus.sample_out), 0);
    endtask

    task automatic do_reset;
        bus.enable = 0; bus.cfg_load = 0; bus.phase_clear = 0;
        bus.cfg_tuning = '0; bus.cfg_offset = '0;
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_s;

        //            en ld clr tuning        off  addr cs wr ack sv
        tbl[0]  = mk(0, 1, 0, 32'h4000_0000, 3,   0,   0, 0, 1, 0);
        tbl[1]  = mk(1, 0, 0, 32'h0,         0,   0,   0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 32'h0,         0,   259, 1, 0, 0, 0);
        tbl[3]  = mk(1, 0, 0, 32'h0,         0,   515, 1, 0, 0, 0);
        tbl[4]  = mk(1, 0, 0, 32'h0,         0,   771, 1, 0, 0, 1);
        tbl[5]  = mk(1, 1, 0, 32'h8000_0000, 5,   3,   1, 1, 0, 1);
        tbl[6]  = mk(1, 1, 0, 32'h8000_0000, 9,   259, 1, 0, 0, 1);
        tbl[7]  = mk(1, 0, 0, 32'h0,         0,   515, 1, 0, 0, 1);
        tbl[8]  = mk(1, 0, 0, 32'h0,         0,   771, 1, 0, 0, 1);
        tbl[9]  = mk(1, 0, 0, 32'h0,         0,   9,   1, 1, 1, 1);
        tbl[10] = mk(1, 0, 0, 32'h0,         0,   521, 1, 0, 0, 1);
        tbl[11] = mk(1, 0, 0, 32'h0,         0,   9,   1, 1, 0, 1);
        tbl[12] = mk(1, 1, 0, 32'h4000_0000, 7,   521, 1, 0, 0, 1);
        tbl[13] = mk(1, 0, 1, 32'h0,         0,   7,   1, 0, 1, 1);
        tbl[14] = mk(1, 0, 0, 32'h0,         0,   263, 1, 0, 0, 1);
        tbl[15] = mk(0, 0, 0, 32'h0,         0,   263, 0, 0, 0, 1);
        tbl[16] = mk(0, 0, 0, 32'h0,         0,   263, 0, 0, 0, 1);
        tbl[17] = mk(0, 0, 0, 32'h0,         0,   263, 0, 0, 0, 0);
        tbl[18] = mk(1, 0, 0, 32'h0,         0,   263, 0, 0, 0, 0);
        tbl[19] = mk(1, 0, 0, 32'h0,         0,   519, 1, 0, 0, 0);
        tbl[20] = mk(1, 0, 0, 32'h0,         0,   775, 1, 0, 0, 0);
        tbl[21] = mk(1, 1, 0, 32'h0,         0,   7,   1, 1, 0, 1);
        tbl[22] = mk(1, 0, 0, 32'h0,         0,   263, 1, 0, 0, 1);
        tbl[23] = mk(1, 0, 0, 32'h0,         0,   519, 1, 0, 0, 1);
        tbl[24] = mk(1, 0, 0, 32'h0,         0,   775, 1, 0, 0, 1);
        tbl[25] = mk(1, 0, 0, 32'h0,         0,   0,   1, 1, 1, 1);
        tbl[26] = mk(1, 1, 0, 32'h4000_0000, 2,   0,   1, 0, 0, 1);
        tbl[27] = mk(1, 0, 0, 32'h0,         0,   0,   1, 0, 0, 1);
        tbl[28] = mk(1, 0, 0, 32'h0,         0,   0,   1, 0, 0, 1);
        tbl[29] = mk(1, 0, 1, 32'h0,         0,   2,   1, 0, 1, 1);
        tbl[30] = mk(1, 0, 0, 32'h0,         0,   258, 1, 0, 0, 1);

        do_reset();
        exp_s = '0;
        for (int i = 0; i < 31; i++) begin
            drive(tbl[i].en, tbl[i].ld, tbl[i].clr, tbl[i].tun, tbl[i].off);
            chk($sformatf("tbl%0d_addr", i), 32'(bus.ram_address), 32'(tbl[i].addr));
            chk($sformatf("tbl%0d_cs", i), 32'(bus.ram_chipselect), 32'(tbl[i].cs));
            chk($sformatf("tbl%0d_wrap", i), 32'(bus.wrap_sync), 32'(tbl[i].wrap));
            chk($sformatf("tbl%0d_ack", i), 32'(bus.cfg_ack), 32'(tbl[i].ack));
            chk($sformatf("tbl%0d_sv", i), 32'(bus.sample_valid), 32'(tbl[i].sv));
            if (tbl[i].sv && i >= 2) exp_s = memf(tbl[i-2].addr);
            chk($sformatf("tbl%0d_sample", i), 32'(bus.sample_out), 32'(exp_s));
        end

        // full 1024-entry sweep at one LUT entry per cycle
        do_reset();
        drive(0, 1, 0, 32'h0040_0000, 0);
        chk("sweep_ack", 32'(bus.cfg_ack), 1);
        drive(1, 0, 0, 0, 0);
        chk("sweep_ack_clear", 32'(bus.cfg_ack), 0);
        for (int n = 1; n <= 1030; n++) begin
            drive(1, 0, 0, 0, 0);
            chk($sformatf("sweep%0d_addr", n), 32'(bus.ram_address), 32'(n % 1024));
            chk($sformatf("sweep%0d_wrap", n), 32'(bus.wrap_sync), 32'(n == 1024));
            if (n >= 3) begin
                chk($sformatf("sweep%0d_sv", n), 32'(bus.sample_valid), 1);
                chk($sformatf("sweep%0d_sample", n), 32'(bus.sample_out), 32'(memf(10'((n - 2) % 1024))));
            end
        end

        // asynchronous reset in the middle of a clock period
        #2;
        reset_n = 0;
        #1;
        check_all_zero("async");
        #1;

        // offset pushes the address across the end of the table
        do_reset();
        drive(0, 1, 0, 32'h0040_0000, 10'd1020);
        drive(1, 0, 0, 0, 0);
        for (int n = 1; n <= 8; n++) begin
            drive(1, 0, 0, 0, 0);
            chk($sformatf("offwrap%0d_addr", n), 32'(bus.ram_address), 32'((n + 1020) % 1024));
            if (n >= 3)
                chk($sformatf("offwrap%0d_sample", n), 32'(bus.sample_out),
                    32'(memf(10'((n - 2 + 1020) % 1024))));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
